tmds_encoder: RTL and testbench

Encodes the final pixel-clock stream from the video timing sink into three 10-bit TMDS symbols per clock for a DVI/HDMI serializer. The block consumes the sink's dataEnable, sync, preamble, guard-band and 8-8-8 RGB outputs. It applies DVI 1.0 8b/10b transition-minimised, DC-balanced coding during active video and control or guard-band codes otherwise. It sits between the timing sink and the 10:1 serializers, entirely in the pixelClock domain.

---
 rtl/tmds_encoder.sv | 170 +++++++++++++++++
 tb/tb_tmds_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// tmds_encoder: three-channel DVI 8b/10b TMDS encoder, 2-cycle latency, pixelClock domain.
// Define TMDS_HDMI_PERIODS_EN to also emit HDMI video preamble and guard-band codes.
module tmds_encoder (
  input  logic       pixelClock,
  input  logic       reset,
  input  logic       dataEnable,
  input  logic       hSync,
  input  logic       vSync,
  input  logic       activeVideoPreamble,
  input  logic       activeVideoGuardBand,
  input  logic [7:0] blue,
  input  logic [7:0] green,
  input  logic [7:0] red,
  output logic [9:0] tmds0,
  output logic [9:0] tmds1,
  output logic [9:0] tmds2
);

  typedef enum logic [1:0] {
    PERIOD_CONTROL,
    PERIOD_DATA,
    PERIOD_GUARD,
    PERIOD_PREAMBLE
  } period_t;

  typedef struct packed {
    logic signed [4:0] cnt;
    logic [9:0]        symbol;
  } balance_t;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
`ifdef TMDS_HDMI_PERIODS_EN
  localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
  localparam logic [9:0] GUARD_ODD  = 10'b0100110011;
`endif

  function automatic logic [9:0] controlCode(input logic [1:0] c);
    case (c)
      2'b01:   controlCode = CTRL_01;
      2'b10:   controlCode = CTRL_10;
      2'b11:   controlCode = CTRL_11;
      default: controlCode = CTRL_00;
    endcase
  endfunction

  function automatic logic [3:0] countOnes(input logic [7:0] d);
    countOnes = 4'd0;
    for (int i = 0; i < 8; i++) countOnes = countOnes + {3'd0, d[i]};
  endfunction

  function automatic logic [8:0] minimiseTransitions(input logic [7:0] d);
    logic [3:0] ones;
    logic       useXnor;
    logic [8:0] q;
    ones    = countOnes(d);
    useXnor = (ones > 4'd4) || (ones == 4'd4 && !d[0]);
    q       = 9'd0;
    q[0]    = d[0];
    for (int i = 1; i < 8; i++) q[i] = useXnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8]    = ~useXnor;
    return q;
  endfunction

  // bias is n1 - n0 of q_m[7:0], always even and within -8..+8
  function automatic balance_t dcBalance(input logic [8:0] qm, input logic signed [4:0] cntIn);
    logic signed [5:0] wideBias;
    logic signed [4:0] bias;
    balance_t          r;
    wideBias = $signed({1'b0, countOnes(qm[7:0]), 1'b0}) - 6'sd8;
    bias     = wideBias[4:0];
    if (cntIn == 5'sd0 || bias == 5'sd0) begin
      r.symbol = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      r.cnt    = qm[8] ? cntIn + bias : cntIn - bias;
    end else if ((cntIn > 5'sd0 && bias > 5'sd0) || (cntIn < 5'sd0 && bias < 5'sd0)) begin
      r.symbol = {1'b1, qm[8], ~qm[7:0]};
      r.cnt    = cntIn + (qm[8] ? 5'sd2 : 5'sd0) - bias;
    end else begin
      r.symbol = {1'b0, qm[8], qm[7:0]};
      r.cnt    = cntIn - (qm[8] ? 5'sd0 : 5'sd2) + bias;
    end
    return r;
  endfunction

  logic [7:0]        pixel [3];
  period_t           periodIn;
  period_t           periodS1;
  logic [1:0]        syncS1;
  logic [8:0]        qmS1 [3];
  logic [1:0]        ctrlBits [3];
  balance_t          balanced [3];
  logic [9:0]        symbolNext [3];
  logic signed [4:0] cntNext [3];
  logic [9:0]        symbol [3];
  logic signed [4:0] cnt [3];

  assign pixel[0] = blue;
  assign pixel[1] = green;
  assign pixel[2] = red;

  always_comb begin
    periodIn = PERIOD_CONTROL;
    if (dataEnable) periodIn = PERIOD_DATA;
`ifdef TMDS_HDMI_PERIODS_EN
    else if (activeVideoGuardBand) periodIn = PERIOD_GUARD;
    else if (activeVideoPreamble) periodIn = PERIOD_PREAMBLE;
`endif
  end

`ifndef TMDS_HDMI_PERIODS_EN
  logic unusedHdmiPeriods;
  assign unusedHdmiPeriods = activeVideoPreamble | activeVideoGuardBand;
`endif

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      periodS1 <= PERIOD_CONTROL;
      syncS1   <= 2'b00;
      for (int ch = 0; ch < 3; ch++) qmS1[ch] <= 9'd0;
    end else begin
      periodS1 <= periodIn;
      syncS1   <= {vSync, hSync};
      for (int ch = 0; ch < 3; ch++) qmS1[ch] <= minimiseTransitions(pixel[ch]);
    end
  end

  always_comb begin
    ctrlBits[0] = syncS1;
    ctrlBits[1] = 2'b00;
    ctrlBits[2] = 2'b00;
`ifdef TMDS_HDMI_PERIODS_EN
    if (periodS1 == PERIOD_PREAMBLE) ctrlBits[1] = 2'b01;
`endif
    for (int ch = 0; ch < 3; ch++) begin
      balanced[ch]   = dcBalance(qmS1[ch], cnt[ch]);
      symbolNext[ch] = controlCode(ctrlBits[ch]);
      cntNext[ch]    = 5'sd0;
      if (periodS1 == PERIOD_DATA) begin
        symbolNext[ch] = balanced[ch].symbol;
        cntNext[ch]    = balanced[ch].cnt;
      end
`ifdef TMDS_HDMI_PERIODS_EN
      else if (periodS1 == PERIOD_GUARD) begin
        symbolNext[ch] = (ch == 1) ? GUARD_ODD : GUARD_EVEN;
      end
`endif
    end
  end

  always_ff @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 3; ch++) begin
        symbol[ch] <= CTRL_00;
        cnt[ch]    <= 5'sd0;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        symbol[ch] <= symbolNext[ch];
        cnt[ch]    <= cntNext[ch];
      end
    end
  end

  assign tmds0 = symbol[0];
  assign tmds1 = symbol[1];
  assign tmds2 = symbol[2];

endmodule

// File: tb/tb_tmds_encoder.sv
// Bench for tmds_encoder: random traffic against a word-disparity reference model plus directed literal checks.
module tb_tmds_encoder;

  logic       pixelClock = 1'b0;
  logic       reset = 1'b0;
  logic       dataEnable = 1'b0;
  logic       hSync = 1'b0;
  logic       vSync = 1'b0;
  logic       activeVideoPreamble = 1'b0;
  logic       activeVideoGuardBand = 1'b0;
  logic [7:0] blue = 8'd0;
  logic [7:0] green = 8'd0;
  logic [7:0] red = 8'd0;
  logic [9:0] tmds0, tmds1, tmds2;

  localparam logic [9:0] CTRL00 = 10'b1101010100;
  localparam logic [9:0] CTRL01 = 10'b0010101011;
  localparam logic [9:0] CTRL11 = 10'b1010101011;
  localparam logic [9:0] GB_A   = 10'b1011001100;
  localparam logic [9:0] GB_B   = 10'b0100110011;
`ifdef TMDS_HDMI_PERIODS_EN
  localparam bit HDMI = 1'b1;
`else
  localparam bit HDMI = 1'b0;
`endif

  tmds_encoder dut (
    .pixelClock           (pixelClock),
    .reset                (reset),
    .dataEnable           (dataEnable),
    .hSync                (hSync),
    .vSync                (vSync),
    .activeVideoPreamble  (activeVideoPreamble),
    .activeVideoGuardBand (activeVideoGuardBand),
    .blue                 (blue),
    .green                (green),
    .red                  (red),
    .tmds0                (tmds0),
    .tmds1                (tmds1),
    .tmds2                (tmds2)
  );

  always #5 pixelClock = ~pixelClock;

  int tests = 0;
  int failures = 0;
  bit checkOn = 1'b0;

  task automatic checkSym(input string name, input logic [9:0] actual, input logic [9:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Reference model: running disparity is simply the ones-minus-zeros of every emitted word.
  int         disp [3];
  logic [9:0] expMid [3];
  logic [9:0] expOut [3];

  function automatic logic [9:0] ctrlCode(input logic [1:0] c);
    case (c)
      2'b00:   return CTRL00;
      2'b01:   return CTRL01;
      2'b10:   return 10'b0101010100;
      default: return CTRL11;
    endcase
  endfunction

  function automatic logic [9:0] encodeData(input logic [7:0] d, input int ch);
    logic [8:0] qm;
    logic [9:0] sym;
    logic       inv;
    int         bal;
    qm[8] = !(($countones(d) > 4) || ($countones(d) == 4 && !d[0]));
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[8] ? (qm[i-1] ^ d[i]) : !(qm[i-1] ^ d[i]);
    bal = 2 * $countones(qm[7:0]) - 8;
    if (disp[ch] == 0 || bal == 0) inv = !qm[8];
    else inv = ((disp[ch] > 0) == (bal > 0));
    sym = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    disp[ch] += 2 * $countones(sym) - 10;
    return sym;
  endfunction

  always @(posedge pixelClock or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 3; ch++) begin
        disp[ch] = 0;
        expMid[ch] = CTRL00;
        expOut[ch] = CTRL00;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) expOut[ch] = expMid[ch];
      if (dataEnable) begin
        expMid[0] = encodeData(blue, 0);
        expMid[1] = encodeData(green, 1);
        expMid[2] = encodeData(red, 2);
      end else begin
        for (int ch = 0; ch < 3; ch++) disp[ch] = 0;
        expMid[0] = ctrlCode({vSync, hSync});
        expMid[1] = CTRL00;
        expMid[2] = CTRL00;
        if (HDMI && activeVideoGuardBand) begin
          expMid[0] = GB_A;
          expMid[1] = GB_B;
          expMid[2] = GB_A;
        end else if (HDMI && activeVideoPreamble) begin
          expMid[1] = CTRL01;
        end
      end
    end
  end

  always @(negedge pixelClock) begin
    if (checkOn) begin
      checkSym("model tmds0", tmds0, expOut[0]);
      checkSym("model tmds1", tmds1, expOut[1]);
      checkSym("model tmds2", tmds2, expOut[2]);
    end
  end

  task automatic drive(input logic de, input logic hs, input logic vs, input logic pre,
                       input logic gb, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    dataEnable = de;
    hSync = hs;
    vSync = vs;
    activeVideoPreamble = pre;
    activeVideoGuardBand = gb;
    red = r;
    green = g;
    blue = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge pixelClock);
  endtask

  logic [23:0] burst [6];
  logic [29:0] rec [14];

  initial begin
    #1 reset = 1'b1;
    tick(1);
    checkOn = 1'b1;
    checkSym("reset tmds0", tmds0, CTRL00);
    checkSym("reset tmds1", tmds1, CTRL00);
    checkSym("reset tmds2", tmds2, CTRL00);
    tick(1);
    reset = 1'b0;
    drive(1, 1, 1, 0, 0, 8'hA5, 8'h3C, 8'hFF);
    tick(1);
    checkSym("post-release tmds0", tmds0, CTRL00);
    checkSym("post-release tmds1", tmds1, CTRL00);
    checkSym("post-release tmds2", tmds2, CTRL00);

    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
            8'($urandom), 8'($urandom), 8'($urandom));
      tick(1);
    end

    drive(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tick(2);
    checkSym("hsync tmds0", tmds0, CTRL01);
    checkSym("hsync tmds1", tmds1, CTRL00);
    checkSym("hsync tmds2", tmds2, CTRL00);
    drive(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    tick(2);
    checkSym("vhsync tmds0", tmds0, CTRL11);

    drive(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tick(2);
    checkSym("zeros first", tmds0, 10'b0100000000);
    tick(1);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    checkSym("zeros second", tmds0, 10'b1111111111);
    tick(1);
    checkSym("zeros third", tmds0, 10'b0100000000);
    tick(1);

    for (int i = 0; i < 6; i++) burst[i] = 24'($urandom);
    for (int i = 0; i < 14; i++) begin
      if (i < 6) drive(1, 0, 0, 0, 0, burst[i][23:16], burst[i][15:8], burst[i][7:0]);
      else if (i >= 7 && i < 13) drive(1, 0, 0, 0, 0, burst[i-7][23:16], burst[i-7][15:8], burst[i-7][7:0]);
      else drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
      tick(1);
      rec[i] = {tmds2, tmds1, tmds0};
    end
    for (int j = 0; j < 6; j++) begin
      checkSym("burst repeat tmds0", rec[j+8][9:0], rec[j+1][9:0]);
      checkSym("burst repeat tmds1", rec[j+8][19:10], rec[j+1][19:10]);
      checkSym("burst repeat tmds2", rec[j+8][29:20], rec[j+1][29:20]);
    end

    drive(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00);
    tick(2);
    checkSym("preamble tmds0", tmds0, CTRL00);
    checkSym("preamble tmds1", tmds1, HDMI ? CTRL01 : CTRL00);
    checkSym("preamble tmds2", tmds2, CTRL00);
    drive(0, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00);
    tick(2);
    checkSym("guard tmds0", tmds0, HDMI ? GB_A : CTRL01);
    checkSym("guard tmds1", tmds1, HDMI ? GB_B : CTRL00);
    checkSym("guard tmds2", tmds2, HDMI ? GB_A : CTRL00);

    drive(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    tick(1);
    drive(1, 0, 0, 0, 0, 8'h10, 8'h20, 8'h40);
    tick(1);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    checkSym("lead guard tmds0", tmds0, HDMI ? GB_A : CTRL00);
    checkSym("lead guard tmds1", tmds1, HDMI ? GB_B : CTRL00);
    checkSym("lead guard tmds2", tmds2, HDMI ? GB_A : CTRL00);
    tick(1);
    checkSym("first pixel tmds0", tmds0, 10'b0111000000);
    checkSym("first pixel tmds1", tmds1, 10'b0111100000);
    checkSym("first pixel tmds2", tmds2, 10'b0111110000);

    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 8'($urandom), 8'($urandom), 8'($urandom));
      tick(1);
    end
    @(posedge pixelClock);
    #2 reset = 1'b1;
    #1;
    checkSym("mid-line reset tmds0", tmds0, CTRL00);
    checkSym("mid-line reset tmds1", tmds1, CTRL00);
    checkSym("mid-line reset tmds2", tmds2, CTRL00);
    tick(2);
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tick(1);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    checkSym("release cycle1 tmds0", tmds0, CTRL00);
    tick(1);
    checkSym("release pixel tmds0", tmds0, 10'b0100000000);
    checkSym("release pixel tmds1", tmds1, 10'b0100000000);
    checkSym("release pixel tmds2", tmds2, 10'b0100000000);

    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), 8'($urandom), 8'($urandom));
      tick(1);
    end
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    tick(3);
    checkOn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
